// File: rtl/gate_op_arbiter.sv
// Shares one registered AND/OR/XOR/NAND unit between N_REQ requesters.
// Ports: clk, reset_n, req_valid/ready/op/a/b (per requester),
//   rsp_valid/ready/id/data, busy.
// Optional macro GATE_ARB_FIXED_PRIO_EN: lowest index always wins.
module gate_op_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  win;
  logic             any_req;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  function automatic logic [WIDTH-1:0] gate_f(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (1'b1)
      (op == 2'b00): r = a & b;
      (op == 2'b01): r = a | b;
      (op == 2'b10): r = a ^ b;
      (op == 2'b11): r = ~(a & b);
      default:       r = '0;
    endcase
    return r;
  endfunction

  assign any_req = |req_valid;

  // Descending scans leave the lowest matching index in win.
  always_comb begin
    win = '0;
`ifdef GATE_ARB_FIXED_PRIO_EN
    for (int j = N_REQ-1; j >= 0; j--)
      if (req_valid[j]) win = ID_W'(j);
`else
    // Wrap fallback: lowest valid overall.
    for (int j = N_REQ-1; j >= 0; j--)
      if (req_valid[j]) win = ID_W'(j);
    // Preferred: lowest valid strictly above last_grant.
    for (int j = N_REQ-1; j >= 0; j--)
      if (req_valid[j] && (j > int'(last_grant)))
        win = ID_W'(j);
`endif
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (win == ID_W'(j)) begin
        sel_op = req_op[2*j +: 2];
        sel_a  = req_a[WIDTH*j +: WIDTH];
        sel_b  = req_b[WIDTH*j +: WIDTH];
      end
    end
  end

  // Mealy grant; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_req && reset_n)
      req_ready = N_REQ'(1) << win;
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cur_id     <= '0;
      last_grant <= ID_W'(N_REQ-1);
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            cur_id     <= win;
            last_grant <= win;
          end
        end
        EXEC: begin
          rsp_data  <= gate_f(op_q, a_q, b_q);
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed self-checking bench for gate_op_arbiter.
// Drives and samples 1ns after each rising edge.
module tb_gate_op_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [2*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0;
  logic [W*N-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic [W-1:0] rsp_data;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  gate_op_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
    req_op[2*i +: 2] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
    req_valid[i]     = 1'b1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Waits for a grant; the accept edge is consumed on return.
  task automatic wait_grant(output int gid, output int cyc, output bit to);
    bit done;
    int k;
    done = 0; k = 0; gid = -1; cyc = 0; to = 1;
    while (!done && k < 20) begin
      #1;
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        cyc = k; to = 0; done = 1;
      end
      tick();
      k++;
    end
  endtask

  // Returns in the first cycle rsp_valid is seen (not consumed).
  task automatic wait_rsp(output int id, output logic [7:0] d, output bit to);
    bit done;
    int k;
    done = 0; k = 0; id = -1; d = '0; to = 1;
    while (!done && k < 20) begin
      if (rsp_valid) begin
        id = int'(rsp_id); d = rsp_data; to = 0; done = 1;
      end else begin
        tick();
      end
      k++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data, req_ready, busy} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset: valid=%b id=%0d data=%h ready=%b busy=%b need all 0",
               rsp_valid, rsp_id, rsp_data, req_ready, busy);
    end
    req_valid = '0;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    drive_req(0, 2'b00, 8'hF0, 8'h3C);
    #1;
    vectors++;
    if (req_ready !== 4'b0001 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_grant: ready=%b busy=%b need 0001/0", req_ready, busy);
    end
    tick();
    req_valid = '0;
    vectors++;
    if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_exec: ready=%b busy=%b valid=%b need 0000/1/0",
               req_ready, busy, rsp_valid);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h30 || rsp_id !== 2'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_rsp: valid=%b data=%h id=%0d busy=%b need 1/30/0/1",
               rsp_valid, rsp_data, rsp_id, busy);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: valid=%b busy=%b need 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_all_opcodes();
    logic [7:0] exp [4];
    int gid, cyc, id;
    bit to1, to2;
    logic [7:0] d;
    exp[0] = 8'h0A; exp[1] = 8'hAF; exp[2] = 8'hA5; exp[3] = 8'hF5;
    do_reset();
    for (int op = 0; op < 4; op++) begin
      drive_req(2, 2'(op), 8'hAA, 8'h0F);
      wait_grant(gid, cyc, to1);
      req_valid = '0;
      wait_rsp(id, d, to2);
      vectors++;
      if (to1 || to2 || gid != 2 || id != 2 || d !== exp[op]) begin
        miscompares++;
        $display("FAIL opcode_%0d: grant=%0d id=%0d data=%h to=%b%b need 2/2/%h",
                 op, gid, id, d, to1, to2, exp[op]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int exp [5];
    int gid, cyc, id;
    bit to1, to2;
    logic [7:0] d;
`ifdef GATE_ARB_FIXED_PRIO_EN
    exp = '{0, 0, 0, 0, 0};
`else
    exp = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int i = 0; i < N; i++) drive_req(i, 2'b01, 8'h10 + 8'(i), 8'h00);
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (!$onehot(req_ready)) begin
        miscompares++;
        $display("FAIL rr_onehot_%0d: ready=%b need one-hot", k, req_ready);
      end
      wait_grant(gid, cyc, to1);
      wait_rsp(id, d, to2);
      vectors++;
      if (to1 || to2 || cyc != 0 || gid != exp[k] || id != exp[k] ||
          d !== 8'h10 + 8'(exp[k])) begin
        miscompares++;
        $display("FAIL rr_%0d: grant=%0d id=%0d data=%h wait=%0d need %0d/%0d/%h/0",
                 k, gid, id, d, cyc, exp[k], exp[k], 8'h10 + 8'(exp[k]));
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int gid, cyc, id;
    bit to1, to2;
    logic [7:0] d;
    do_reset();
    rsp_ready = 1'b0;
    drive_req(1, 2'b10, 8'h5A, 8'hFF);
    wait_grant(gid, cyc, to1);
    req_valid = '0;
    drive_req(3, 2'b00, 8'hFF, 8'h81);
    wait_rsp(id, d, to2);
    vectors++;
    if (to1 || to2 || gid != 1 || id != 1 || d !== 8'hA5) begin
      miscompares++;
      $display("FAIL bp_first: grant=%0d id=%0d data=%h need 1/1/a5", gid, id, d);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_id !== 2'd1 ||
          req_ready !== 4'b0000 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: valid=%b data=%h id=%0d ready=%b busy=%b need 1/a5/1/0000/1",
                 k, rsp_valid, rsp_data, rsp_id, req_ready, busy);
      end
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_ready_resp: ready=%b need 0000", req_ready);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL bp_release: busy=%b valid=%b ready=%b need 0/0/1000",
               busy, rsp_valid, req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_op();
    int gid, cyc, id, spurious;
    bit to1, to2;
    logic [7:0] d;
    do_reset();
    drive_req(0, 2'b00, 8'hFF, 8'hFF);
    wait_grant(gid, cyc, to1);
    req_valid = '0;
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (to1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b busy=%b need 0/0", rsp_valid, busy);
    end
    tick();
    reset_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_valid || busy) spurious++;
    end
    vectors++;
    if (spurious != 0) begin
      miscompares++;
      $display("FAIL mid_no_rsp: %0d active cycles need 0", spurious);
    end
    drive_req(3, 2'b11, 8'h0F, 8'hFF);
    wait_grant(gid, cyc, to1);
    req_valid = '0;
    wait_rsp(id, d, to2);
    vectors++;
    if (to1 || to2 || gid != 3 || id != 3 || d !== 8'hF0) begin
      miscompares++;
      $display("FAIL mid_first_grant: grant=%0d id=%0d data=%h need 3/3/f0", gid, id, d);
    end
    tick();
  endtask

  task automatic test_wrap_withdraw();
    int gid, cyc, id, extra;
    bit to1, to2;
    logic [7:0] d;
    do_reset();
    rsp_ready = 1'b0;
    drive_req(3, 2'b01, 8'h01, 8'h02);
    wait_grant(gid, cyc, to1);
    req_valid = '0;
    drive_req(1, 2'b00, 8'h11, 8'h11);
    drive_req(2, 2'b10, 8'hC3, 8'h3C);
    wait_rsp(id, d, to2);
    vectors++;
    if (to1 || to2 || gid != 3 || id != 3 || d !== 8'h03) begin
      miscompares++;
      $display("FAIL wrap_setup: grant=%0d id=%0d data=%h need 3/3/03", gid, id, d);
    end
    tick();
    req_valid[1] = 1'b0;
    rsp_ready = 1'b1;
    tick();
    wait_grant(gid, cyc, to1);
    req_valid = '0;
    wait_rsp(id, d, to2);
    vectors++;
    if (to1 || to2 || gid != 2 || id != 2 || d !== 8'hFF) begin
      miscompares++;
      $display("FAIL wrap_grant: grant=%0d id=%0d data=%h need 2/2/ff", gid, id, d);
    end
    tick();
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid || busy) extra++;
      tick();
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL wrap_no_extra: %0d active cycles need 0", extra);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_all_opcodes();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_wrap_withdraw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
